// File: rtl/logic_unit_pkg.sv
// Shared definitions for the pipelined bitwise logic unit: op encoding and popcount width.
// The optional popcount output is enabled with LOGIC_UNIT_POPCNT_EN.
package logic_unit_pkg;

  typedef logic [2:0] op_t;

  localparam op_t OP_AND   = 3'b000;
  localparam op_t OP_OR    = 3'b001;
  localparam op_t OP_XOR   = 3'b010;
  localparam op_t OP_NOR   = 3'b011;
  localparam op_t OP_NAND  = 3'b100;
  localparam op_t OP_XNOR  = 3'b101;
  localparam op_t OP_ANDN  = 3'b110;
  localparam op_t OP_PASSA = 3'b111;

  function automatic int popcnt_w(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/logic_unit_core.sv
// Combinational op/A/B -> result selector feeding the first pipeline stage.
module logic_unit_core
  import logic_unit_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  op_t              op_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic [WIDTH-1:0] res_o
);

  always_comb begin
    case (op_i)
      OP_AND:  res_o = a_i & b_i;
      OP_OR:   res_o = a_i | b_i;
      OP_XOR:  res_o = a_i ^ b_i;
      OP_NOR:  res_o = ~(a_i | b_i);
      OP_NAND: res_o = ~(a_i & b_i);
      OP_XNOR: res_o = ~(a_i ^ b_i);
      OP_ANDN: res_o = a_i & ~b_i;
      default: res_o = a_i;
    endcase
  end

endmodule

// File: rtl/logic_unit_pipe.sv
// Two-stage bitwise logic unit with valid/ready at both ends and full backpressure.
// Defining LOGIC_UNIT_POPCNT_EN adds a popcnt output computed alongside the flags.
module logic_unit_pipe
  import logic_unit_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int TAG_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [2:0]       op,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] C,
  output logic             zero,
  output logic             ones,
  output logic [TAG_W-1:0] out_tag
`ifdef LOGIC_UNIT_POPCNT_EN
  ,
  output logic [popcnt_w(WIDTH)-1:0] popcnt
`endif
);

  logic             s1_valid_q, s1_valid_d;
  logic [WIDTH-1:0] s1_res_q;
  logic [TAG_W-1:0] s1_tag_q;
  logic             s2_valid_q, s2_valid_d;
  logic [WIDTH-1:0] c_q;
  logic             zero_q, ones_q;
  logic [TAG_W-1:0] s2_tag_q;
  logic [WIDTH-1:0] core_res;
  logic             s1_adv, s2_adv, s1_load, s2_load;
  logic             zero_d, ones_d;

  logic_unit_core #(.WIDTH(WIDTH)) u_core (
    .op_i  (op),
    .a_i   (A),
    .b_i   (B),
    .res_o (core_res)
  );

  // A stage may advance when it is empty or its downstream is advancing.
  assign s2_adv   = !s2_valid_q | out_ready;
  assign s1_adv   = !s1_valid_q | s2_adv;
  assign in_ready = s1_adv;

  assign s1_load    = s1_adv & in_valid;
  assign s2_load    = s2_adv & s1_valid_q;
  assign s1_valid_d = s1_adv ? in_valid : s1_valid_q;
  assign s2_valid_d = s2_adv ? s1_valid_q : s2_valid_q;
  assign zero_d     = (s1_res_q == '0);
  assign ones_d     = &s1_res_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s1_res_q   <= '0;
      s1_tag_q   <= '0;
      s2_valid_q <= 1'b0;
      c_q        <= '0;
      zero_q     <= 1'b0;
      ones_q     <= 1'b0;
      s2_tag_q   <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s2_valid_q <= s2_valid_d;
      if (s1_load) begin
        s1_res_q <= core_res;
        s1_tag_q <= in_tag;
      end
      if (s2_load) begin
        c_q      <= s1_res_q;
        zero_q   <= zero_d;
        ones_q   <= ones_d;
        s2_tag_q <= s1_tag_q;
      end
    end
  end

  assign out_valid = s2_valid_q;
  assign C         = c_q;
  assign zero      = zero_q;
  assign ones      = ones_q;
  assign out_tag   = s2_tag_q;

`ifdef LOGIC_UNIT_POPCNT_EN
  localparam int PCW = popcnt_w(WIDTH);
  logic [PCW-1:0] popcnt_d, popcnt_q;

  always_comb begin
    popcnt_d = '0;
    for (int i = 0; i < WIDTH; i++) begin
      popcnt_d = popcnt_d + PCW'(s1_res_q[i]);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      popcnt_q <= '0;
    end else if (s2_load) begin
      popcnt_q <= popcnt_d;
    end
  end

  assign popcnt = popcnt_q;
`endif

endmodule
